// File: rtl/seg_scan_decoder.sv
// Readback decoder for a multiplexed, active-low 4-digit 7-segment display.
// Captures each settled digit and reassembles the full BCD frame.
module seg_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned DIGIT_LAG      = 1,
  parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anode,
  input  logic [6:0]  seg,
  output logic [15:0] value,
  output logic        frame_valid,
  output logic        frame_changed,
  output logic        frame_error,
  output logic [3:0]  blank_mask,
  output logic        display_dark
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    LAG         = 2'(DIGIT_LAG % 4);

  logic [3:0]    anode_q;
  logic [6:0]    seg_q;
  logic [SW-1:0] settle_q, settle_d;
  logic          captured_q, captured_d;
  logic [3:0]    mask_q, mask_d;
  logic [15:0]   stage_q, stage_d;
  logic [3:0]    err_q, err_d;
  logic [3:0]    blk_q, blk_d;
  logic [TW-1:0] to_q, to_d;
  logic [15:0]   value_q, value_d;
  logic          fv_q, fv_d;
  logic          fc_q, fc_d;
  logic          ferr_q, ferr_d;
  logic [3:0]    bm_q, bm_d;
  logic          dark_q, dark_d;

  logic [1:0] slot, tgt;
  logic       slot_vld, same, capture, commit, timeout;
  logic [5:0] dec;

  // Returns {error, blank, digit}; input is the raw active-low segment bus.
  function automatic logic [5:0] seg_decode(input logic [6:0] raw);
    logic [6:0] lit;
    logic [5:0] r;
    lit = ~raw;
    r   = {2'b10, 4'hE};
    case (lit)
      7'b0111111: r = {2'b00, 4'd0};
      7'b0000110: r = {2'b00, 4'd1};
      7'b1011011: r = {2'b00, 4'd2};
      7'b1001111: r = {2'b00, 4'd3};
      7'b1100110: r = {2'b00, 4'd4};
      7'b1101101: r = {2'b00, 4'd5};
      7'b1111101: r = {2'b00, 4'd6};
      7'b0000111: r = {2'b00, 4'd7};
      7'b1111111: r = {2'b00, 4'd8};
      7'b1101111: r = {2'b00, 4'd9};
      7'b0000000: r = {2'b01, 4'hF};
      default:    r = {2'b10, 4'hE};
    endcase
    return r;
  endfunction

  always_comb begin
    slot     = 2'd0;
    slot_vld = 1'b1;
    case (anode)
      4'b0111: slot = 2'd0;
      4'b1110: slot = 2'd1;
      4'b1101: slot = 2'd2;
      4'b1011: slot = 2'd3;
      default: slot_vld = 1'b0;
    endcase
    tgt  = slot - LAG;
    dec  = seg_decode(seg);
    same = (anode == anode_q) && (seg == seg_q);

    if (!slot_vld || !same)          settle_d = '0;
    else if (settle_q != SETTLE_LAST) settle_d = settle_q + SW'(1);
    else                              settle_d = settle_q;

    capture = slot_vld && same && !captured_q && (settle_d == SETTLE_LAST);

    if (!slot_vld || !same) captured_d = 1'b0;
    else if (capture)       captured_d = 1'b1;
    else                    captured_d = captured_q;

    if (capture)              to_d = '0;
    else if (to_q == TO_LAST) to_d = to_q;
    else                      to_d = to_q + TW'(1);
    timeout = !capture && (to_d == TO_LAST);

    commit  = (mask_q == 4'hF);

    stage_d = stage_q;
    err_d   = err_q;
    blk_d   = blk_q;
    mask_d  = mask_q;
    if (commit || timeout) begin
      mask_d = '0;
      err_d  = '0;
      blk_d  = '0;
    end
    // Capture is applied after the clears so a same-cycle capture always survives.
    if (capture) begin
      stage_d[{tgt, 2'b00} +: 4] = dec[3:0];
      err_d[tgt]  = dec[5];
      blk_d[tgt]  = dec[4];
      mask_d[tgt] = 1'b1;
    end

    value_d = value_q;
    fv_d    = 1'b0;
    fc_d    = 1'b0;
    ferr_d  = ferr_q;
    bm_d    = bm_q;
    dark_d  = dark_q;
    if (commit) begin
      value_d = stage_q;
      fv_d    = 1'b1;
      fc_d    = (stage_q != value_q);
      ferr_d  = |err_q;
      bm_d    = blk_q;
      dark_d  = 1'b0;
    end
    if (timeout) dark_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anode_q    <= '0;
      seg_q      <= '0;
      settle_q   <= '0;
      captured_q <= 1'b0;
      mask_q     <= '0;
      stage_q    <= '0;
      err_q      <= '0;
      blk_q      <= '0;
      to_q       <= '0;
      value_q    <= '0;
      fv_q       <= 1'b0;
      fc_q       <= 1'b0;
      ferr_q     <= 1'b0;
      bm_q       <= '0;
      dark_q     <= 1'b1;
    end else begin
      anode_q    <= anode;
      seg_q      <= seg;
      settle_q   <= settle_d;
      captured_q <= captured_d;
      mask_q     <= mask_d;
      stage_q    <= stage_d;
      err_q      <= err_d;
      blk_q      <= blk_d;
      to_q       <= to_d;
      value_q    <= value_d;
      fv_q       <= fv_d;
      fc_q       <= fc_d;
      ferr_q     <= ferr_d;
      bm_q       <= bm_d;
      dark_q     <= dark_d;
    end
  end

  assign value         = value_q;
  assign frame_valid   = fv_q;
  assign frame_changed = fc_q;
  assign frame_error   = ferr_q;
  assign blank_mask    = bm_q;
  assign display_dark  = dark_q;

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed 7-segment display driver.
- Watches the active-low anode and segment buses as they are driven to the board. Decodes each digit pattern back to BCD and reassembles the full 4-digit frame (mm:ss) as a 16-bit value.
- Used as an on-chip readback/self-check: its outputs feed the debug LEDs and the bench scoreboard, so displayed time can be compared against the internal current_time/alarm_time registers.

Parameters:
- SETTLE_CYCLES, 16, consecutive clk cycles anode+seg must be unchanged before a digit is captured (minimum 2).
- DIGIT_LAG, 1, anode-to-segment pipeline skew in digit slots. A pattern seen while slot k is selected is attributed to slot (k - DIGIT_LAG) mod 4.
- TIMEOUT_CYCLES, 2^20, clk cycles without any capture before the display is declared dark.

Ports:
- clk  input  1  system clock (clk_osc domain; anode/seg sampled directly, no synchroniser needed)
- reset  input  1  asynchronous, active-high
- anode  input  4  display anode bus, active-low
- seg  input  7  segment bus, active-low, bit0=a … bit6=g
- value  output  16  last complete frame, BCD; [15:12]=slot3 … [3:0]=slot0
- frame_valid  output  1  one-cycle pulse when value updates
- frame_changed  output  1  one-cycle pulse, coincident with frame_valid, when new value != previous value
- frame_error  output  1  held with value: 1 if any digit of that frame was invalid
- blank_mask  output  4  held with value: bit k=1 if slot k was blank
- display_dark  output  1  level; timeout expired with no capture

Behaviour:
- Reset (async): value=0, frame_valid=0, frame_changed=0, frame_error=0, blank_mask=0, display_dark=1.
- Reset also clears settle counter, capture mask, captured flag, and timeout counter.
- Slot decode of anode:
  - 0111 -> slot0, 1110 -> slot1, 1101 -> slot2, 1011 -> slot3.
  - Any other value (1111, multi-low) is idle: settle counter cleared, no capture.
- Settle:
  - Register previous anode/seg each cycle.
  - Settle counter increments while both are unchanged and the slot is valid; clears to 0 on any change.
  - Capture exactly once per dwell, on the cycle the counter reaches SETTLE_CYCLES-1. A captured flag blocks repeat capture until anode or seg changes.
- Segment decode (raw active-low seg, inverted first):
  - Digits 0-9: 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111101, 0000111, 1111111, 1101111 -> 0-9.
  - 0000000 -> digit 0xF, blank bit set.
  - Anything else -> digit 0xE, error bit set.
  - All-segments-on (alarm flash) decodes as 8; no special case.
- Frame assembly:
  - Captured digit is written to slot (k - DIGIT_LAG) mod 4 in a staging register, and the corresponding capture-mask bit is set.
  - Re-capturing an already-set slot overwrites its digit and flags; the mask is unchanged.
- Frame commit: when the mask becomes 1111 (same cycle as the 4th capture, using the new digit), then on the next clk edge:
  - value <= staging, frame_error <= OR of the per-slot error bits, blank_mask <= per-slot blank bits.
  - frame_valid=1 for one cycle; frame_changed=1 if staging != old value.
  - Mask and error/blank staging cleared.
  - Latency: 1 clk from the capturing edge.
- Timeout:
  - Counter increments each cycle and clears on every capture.
  - Saturates at TIMEOUT_CYCLES-1; on reaching it, display_dark=1 and the capture mask is cleared. Partial frames are discarded; value is retained.
  - display_dark clears on the next commit, not on a single capture.
- Simultaneous events: capture and timeout in the same cycle -> capture wins (counter cleared, no mask clear).
- Widths: counters sized by $clog2 of their parameter. No arithmetic overflow is possible: all counters saturate.

Test Plan:
- Scan slots 0..3 (DIGIT_LAG=0) with patterns for 1,2,3,4, each dwelling 20 cycles -> one frame_valid, value=16'h4321, frame_changed=1, frame_error=0, blank_mask=0.
- Repeat the identical scan -> frame_valid=1, frame_changed=0, value unchanged.
- Dwell of only SETTLE_CYCLES-2 cycles on slot2 (glitch), then a full scan of 5,9,5,9 -> value=16'h5959 exactly once; no capture from the glitch.
- Slot1 shows raw seg 7'b1010101 (invalid) and slot3 shows raw 1111111 (blank) -> value=16'hF?E? with the valid digits in place, frame_error=1, blank_mask=4'b1000.
- DIGIT_LAG=1, seg for digit d_k presented while slot k+1 is selected -> value reassembled to the original digits.
- Anode held at 1111 for TIMEOUT_CYCLES after two captures -> display_dark=1, partial frame discarded, value retained. Assert reset mid-frame -> all outputs at reset values immediately, asynchronously.
